// File: rtl/lif_pkg.sv
// Shared constants for the LIF spike monitor: event-word layout, FSM encoding, default sizes.
package lif_pkg;

  localparam int TS_W_DEF       = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int EVT_W         = 16;
  localparam int EVT_TS_MSB    = 15;
  localparam int EVT_TS_LSB    = 8;
  localparam int EVT_VMEM_MSB  = 7;
  localparam int EVT_VMEM_LSB  = 1;
  localparam int EVT_EPOCH_BIT = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lif_state_e;

endpackage

// File: rtl/lif_spike_monitor_if.sv
// Event read port of the spike monitor: first-word-fall-through head with pop request.
interface lif_spike_monitor_if;
  logic        rd_en;
  logic        evt_valid;
  logic [15:0] evt_data;

  modport master (input rd_en, output evt_valid, output evt_data);
  modport slave  (output rd_en, input evt_valid, input evt_data);
endinterface

// File: rtl/lif_event_fifo.sv
// Event FIFO with same-cycle push/pop (also when full) and a synchronous clear that wins over both.
module lif_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !clear && !empty;
  // When full, the write slot equals the slot being popped, so a coincident pop frees it.
  assign push_ok = push && !clear && (!full || pop_ok);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lif_spike_monitor.sv
// Timestamps rising edges of a LIF neuron spike output and queues them as 16-bit events.
// Build option LIF_SPIKE_MON_VMEM_CAPTURE_EN stores the membrane potential snapshot in each event.
//
// state   | meaning
// IDLE    | waiting for enable && params_ready; timestamp held, no detection
// RUN     | timestamp counting, rising spike edges pushed as events
module lif_spike_monitor
  import lif_pkg::*;
#(
  parameter int TS_W       = TS_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                params_ready,
  input  logic                spike_in,
  input  logic [6:0]          v_mem_in,
  input  logic                clear,
  lif_spike_monitor_if.master evt,
  output logic [2:0]          fifo_count,
  output logic [7:0]          spike_count,
  output logic                overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef LIF_SPIKE_MON_VMEM_CAPTURE_EN
  localparam int STORE_W = EVT_W;
`else
  localparam int STORE_W = 9;
`endif

  lif_state_e         state;
  lif_state_e         state_nxt;
  logic               ts_load;
  logic               ts_inc;
  logic [TS_W-1:0]    ts;
  logic               epoch;
  logic               spike_d;
  logic               detect;
  logic [7:0]         ts_field;
  logic [STORE_W-1:0] push_word;
  logic [STORE_W-1:0] head_word;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_cnt;
  logic               pop_req;
  logic               drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ts_load   = 1'b0;
    ts_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && params_ready) begin
          state_nxt = ST_RUN;
          ts_load   = 1'b1;
        end
      end
      ST_RUN: begin
        ts_inc = 1'b1;
        if (!enable || !params_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts    <= '0;
      epoch <= 1'b0;
    end else if (ts_load) begin
      ts    <= '0;
      epoch <= 1'b0;
    end else if (ts_inc) begin
      ts <= ts + TS_W'(1);
      if (ts == '1) epoch <= ~epoch;
    end
  end

  // Edge register samples every cycle so a spike already high on RUN entry is not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) spike_d <= 1'b0;
    else        spike_d <= spike_in;
  end

  assign detect   = (state == ST_RUN) && spike_in && !spike_d;
  assign ts_field = 8'(ts);
  assign pop_req  = evt.rd_en && !fifo_empty;
  assign drop     = detect && fifo_full && !pop_req;

`ifdef LIF_SPIKE_MON_VMEM_CAPTURE_EN
  assign push_word    = {ts_field, v_mem_in, epoch};
  assign evt.evt_data = fifo_empty ? '0 : head_word;
`else
  logic vmem_unused;
  assign vmem_unused  = ^v_mem_in;
  assign push_word    = {ts_field, epoch};
  assign evt.evt_data = fifo_empty ? '0 : {head_word[8:1], 7'b0, head_word[0]};
`endif

  lif_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (STORE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (detect),
    .pop       (evt.rd_en),
    .push_data (push_word),
    .head_data (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign evt.evt_valid = !fifo_empty;
  assign fifo_count    = 3'(fifo_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spike_count <= 8'd0;
      overflow    <= 1'b0;
    end else if (clear) begin
      spike_count <= 8'd0;
      overflow    <= 1'b0;
    end else begin
      if (detect && spike_count != 8'hFF) spike_count <= spike_count + 8'd1;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule
